// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch stage
package cpu_pkg;
    localparam int WORD_W = 32;
    localparam int IMEM_SIZE = 64;
    localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;
    typedef enum logic {RUN, HALT} fetch_state_t;
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instruction;
    } fetch_entry_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: imem, redirect and decode-side signals of the fetch stage
interface instruction_fetch_if;
    import cpu_pkg::*;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_instruction;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_pc;
    logic [WORD_W-1:0] out_instruction;
    logic              halted;
    modport master (
        output imem_addr, out_valid, out_pc, out_instruction, halted,
        input  imem_instruction, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  imem_addr, out_valid, out_pc, out_instruction, halted,
        output imem_instruction, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: 2-entry buffer of fetched {pc, instruction} pairs with flush
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t mem [2];
    logic rd_ptr;
    logic wr_ptr;
    logic do_pop;
    assign do_pop = pop && count != 2'd0;
    assign head = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(do_pop);
        end
    end
    // The issue throttle upstream guarantees a free slot for every return
    assert property (@(posedge clk) disable iff (rst) !(push && !flush && count == 2'd2));
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner, imem initiator and buffered {pc, instruction} source for decode
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter int          IMEM_SIZE = cpu_pkg::IMEM_SIZE
) (
    input logic                 clk,
    input logic                 rst,
    instruction_fetch_if.master bus
);
    localparam logic [31:0] LIMIT = 32'(IMEM_SIZE * 4);
    cpu_pkg::fetch_state_t state, state_n;
    cpu_pkg::fetch_entry_t din, head;
    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic [31:0] target;
    logic [1:0]  count;
    logic        inflight;
    logic        issue;
    logic        pop;
    logic        push;
    assign target = bus.redirect_pc & ~32'h3;
    assign pop = bus.out_valid && bus.out_ready;
    // A redirect drops the word returning this cycle
    assign push = inflight && !bus.redirect_valid;
    assign din = '{pc: inflight_pc, instruction: bus.imem_instruction};
    assign bus.imem_addr = fetch_pc;
    assign bus.out_valid = count != 2'd0;
    assign bus.out_pc = bus.out_valid ? head.pc : '0;
    assign bus.out_instruction = bus.out_valid ? head.instruction : '0;
    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.redirect_valid),
        .din   (din),
        .head  (head),
        .count (count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= cpu_pkg::RUN;
        else     state <= state_n;
    end
    always_comb begin
        state_n = bus.redirect_valid ? (target >= LIMIT ? cpu_pkg::HALT : cpu_pkg::RUN)
                : (issue && fetch_pc + 32'd4 == LIMIT) ? cpu_pkg::HALT : state;
    end
    // Occupancy plus the word in flight is capped at the FIFO depth
    always_comb begin
        issue = state == cpu_pkg::RUN && !bus.redirect_valid
                && ({1'b0, count} + 3'(inflight) - 3'(pop)) < 3'd2;
        bus.halted = state == cpu_pkg::HALT && count == 2'd0 && !inflight;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (bus.redirect_valid) begin
                fetch_pc <= target;
            end else if (issue) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end
endmodule
